// File: rtl/rle_block_expander.sv
// rle_block_expander: expands packed (run, level) words into one BLK-coefficient block.
// Optional ZIGZAG_EN (BLK=64 only) drains in raster order through the JPEG zigzag table.
module rle_block_expander #(
    parameter int RUN_W = 6,
    parameter int LVL_W = 8,
    parameter int PAIRS = 8,
    parameter int BLK   = 64,
    parameter int IDX_W = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [PAIRS*(RUN_W+LVL_W)-1:0] in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [LVL_W-1:0]               out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           err
);
    localparam int PW   = RUN_W + LVL_W;
    localparam int PI_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int TW   = ((RUN_W > IDX_W) ? RUN_W : IDX_W) + 1;
    localparam logic [RUN_W-1:0] EOB = '1;

    typedef enum logic [1:0] {S_LOAD, S_EXPAND, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [PAIRS*PW-1:0] word_q, word_d;
    logic [PI_W-1:0]     pidx_q, pidx_d;
    logic [IDX_W-1:0]    pos_q, pos_d;
    logic [IDX_W-1:0]    rd_q, rd_d;
    logic [BLK-1:0]      wr_q, wr_d;
    logic                err_q, err_d;
    logic [LVL_W-1:0]    buf_q [BLK];

    logic [PW-1:0]       pair_arr [PAIRS];
    logic [PW-1:0]       pair;
    logic [RUN_W-1:0]    run;
    logic [LVL_W-1:0]    lvl;
    logic [TW-1:0]       tgt;
    logic                buf_we;
    logic                done;
    logic [IDX_W-1:0]    rd_addr;

`ifdef ZIGZAG_EN
    // Raster position -> scan position of the standard JPEG zigzag.
    localparam logic [5:0] ZZ [64] = '{
         0,  1,  5,  6, 14, 15, 27, 28,
         2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,
         9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54,
        20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61,
        35, 36, 48, 49, 57, 58, 62, 63
    };
    assign rd_addr = IDX_W'(ZZ[rd_q]);
`else
    assign rd_addr = rd_q;
`endif

    always_comb begin
        for (int i = 0; i < PAIRS; i++) begin
            pair_arr[i] = word_q[(PAIRS-1-i)*PW +: PW];
        end
    end

    assign pair = pair_arr[pidx_q];
    assign run  = pair[PW-1:LVL_W];
    assign lvl  = pair[LVL_W-1:0];
    assign tgt  = TW'(pos_q) + TW'(run);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        pidx_d  = pidx_q;
        pos_d   = pos_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = 1'b0;
        buf_we  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    word_d  = in_data;
                    pidx_d  = '0;
                    state_d = S_EXPAND;
                end
            end
            S_EXPAND: begin
                if (run == EOB) begin
                    done = 1'b1;
                end else if (tgt >= TW'(BLK)) begin
                    err_d = 1'b1;
                    done  = 1'b1;
                end else begin
                    buf_we                 = 1'b1;
                    wr_d[tgt[IDX_W-1:0]]   = 1'b1;
                    pos_d = tgt[IDX_W-1:0] + IDX_W'(1);
                    done  = (tgt == TW'(BLK-1));
                end
                // Unconsumed pairs after completion are dropped.
                if (done) begin
                    state_d = S_DRAIN;
                end else if (pidx_q == PI_W'(PAIRS-1)) begin
                    state_d = S_LOAD;
                end else begin
                    pidx_d = pidx_q + PI_W'(1);
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (rd_q == IDX_W'(BLK-1)) begin
                        rd_d    = '0;
                        pos_d   = '0;
                        wr_d    = '0;
                        state_d = S_LOAD;
                    end else begin
                        rd_d = rd_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOAD;
            word_q  <= '0;
            pidx_q  <= '0;
            pos_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            pidx_q  <= pidx_d;
            pos_q   <= pos_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    // Contents are masked by the written vector, so no reset is needed.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[tgt[IDX_W-1:0]] <= lvl;
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_DRAIN);
    assign out_last  = out_valid && (rd_q == IDX_W'(BLK-1));
    assign out_data  = wr_q[rd_addr] ? buf_q[rd_addr] : '0;
    assign err       = err_q;

endmodule

// File: tb/tb_rle_block_expander.sv
// tb_rle_block_expander: scoreboard bench for rle_block_expander.
// Expected blocks come from a bench-side expansion model; zigzag order is walked, not tabled.
`timescale 1ns/1ps
module tb_rle_block_expander;
    localparam int RUN_W = 6;
    localparam int LVL_W = 8;
    localparam int PAIRS = 8;
    localparam int BLK   = 64;
    localparam int IDX_W = 6;
    localparam int PW    = RUN_W + LVL_W;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [PAIRS*PW-1:0]     in_data = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [LVL_W-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic                    out_last;
    logic                    err;

    rle_block_expander #(
        .RUN_W(RUN_W), .LVL_W(LVL_W), .PAIRS(PAIRS), .BLK(BLK), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int beats = 0;
    int err_cnt = 0;
    logic [LVL_W-1:0] sb[$];
    logic [PW-1:0]    pq[$];
    bit               stall_prev = 0;
    logic [LVL_W-1:0] held_d;
    logic             held_l;
    logic [LVL_W-1:0] exp_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (beat %0d, t=%0t)", tag, obs, exp, beats, $time);
        end
    endtask

    function automatic logic [PW-1:0] pr(input int r, input int l);
        return {RUN_W'(r), LVL_W'(l)};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 0;
        end else begin
            if (err) err_cnt++;
            if (out_valid) begin
                check("in_ready_in_drain", 32'(in_ready), 0);
                if (stall_prev) begin
                    check("stall_data", 32'(out_data), 32'(held_d));
                    check("stall_last", 32'(out_last), 32'(held_l));
                end
                if (!out_ready) begin
                    stall_prev = 1;
                    held_d = out_data;
                    held_l = out_last;
                end else begin
                    stall_prev = 0;
                    check("sb_nonempty", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        exp_d = sb.pop_front();
                        check("out_data", 32'(out_data), 32'(exp_d));
                    end
                    check("out_last", 32'(out_last), 32'(beats == BLK-1));
                    beats++;
                end
            end else begin
                stall_prev = 0;
            end
        end
    end

    task automatic model_push(output int exp_err);
        logic [LVL_W-1:0] m [BLK];
        int nat [BLK];
        logic [LVL_W-1:0] o [BLK];
        int pos, r, c;
        bit done;
        for (int i = 0; i < BLK; i++) m[i] = '0;
        pos = 0;
        done = 0;
        exp_err = 0;
        foreach (pq[i]) begin
            if (!done) begin
                r = int'(pq[i][PW-1:LVL_W]);
                if (r == (1 << RUN_W) - 1) begin
                    done = 1;
                end else if (pos + r >= BLK) begin
                    exp_err = 1;
                    done = 1;
                end else begin
                    m[pos+r] = pq[i][LVL_W-1:0];
                    pos = pos + r + 1;
                    if (pos == BLK) done = 1;
                end
            end
        end
        r = 0;
        c = 0;
        for (int s = 0; s < BLK; s++) begin
            nat[s] = r * 8 + c;
            if (((r + c) % 2) == 0) begin
                if (c == 7) r++;
                else if (r == 0) c++;
                else begin r--; c++; end
            end else begin
                if (r == 7) c++;
                else if (c == 0) r++;
                else begin r++; c--; end
            end
        end
`ifdef ZIGZAG_EN
        for (int s = 0; s < BLK; s++) o[nat[s]] = m[s];
`else
        for (int s = 0; s < BLK; s++) o[s] = m[s];
        if (nat[2] != 8) $display("zigzag walk inconsistent");
`endif
        for (int i = 0; i < BLK; i++) sb.push_back(o[i]);
    endtask

    task automatic send_all();
        logic [PAIRS*PW-1:0] word;
        int t;
        for (int w = 0; w < pq.size() / PAIRS; w++) begin
            for (int p = 0; p < PAIRS; p++) word[(PAIRS-1-p)*PW +: PW] = pq[w*PAIRS+p];
            @(posedge clk);
            #1;
            in_data = word;
            in_valid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!in_ready && t < 200);
            check("in_ready_wait", 32'(in_ready), 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain(input logic [3:0] pat);
        int k;
        k = 0;
        while (beats < BLK && k < 2000) begin
            @(posedge clk);
            #1;
            out_ready = pat[k % 4];
            k++;
        end
        out_ready = 1'b1;
        check("drain_done", 32'(beats >= BLK), 1);
    endtask

    task automatic do_block(input logic [3:0] pat);
        int ee;
        beats = 0;
        err_cnt = 0;
        model_push(ee);
        send_all();
        drain(pat);
        repeat (3) @(negedge clk);
        check("beats", 32'(beats), BLK);
        check("err_cnt", 32'(err_cnt), 32'(ee));
        check("in_ready_after", 32'(in_ready), 1);
        check("out_valid_after", 32'(out_valid), 0);
        check("sb_empty", 32'(sb.size()), 0);
        pq.delete();
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_err", 32'(err), 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);

        pq = '{pr(0, 5), pr(2, -3), pr(63, 0), pr(0, 9), pr(0, 9), pr(0, 9), pr(0, 9), pr(0, 9)};
        do_block(4'b1111);

        for (int i = 1; i <= 64; i++) pq.push_back(pr(0, i));
        do_block(4'b1111);

        pq = '{pr(40, 7), pr(30, 9), pr(0, 1), pr(0, 1), pr(0, 1), pr(0, 1), pr(0, 1), pr(0, 1)};
        do_block(4'b1111);

        pq = '{pr(0, 5), pr(2, -3), pr(63, 0), pr(0, 9), pr(0, 9), pr(0, 9), pr(0, 9), pr(0, 9)};
        do_block(4'b1001);

        beats = 0;
        for (int i = 1; i <= 64; i++) pq.push_back(pr(0, i + 100));
        begin
            int ee;
            model_push(ee);
        end
        send_all();
        k = 0;
        while (beats < 20 && k < 1000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("abort_reached", 32'(beats >= 20), 1);
        reset = 1'b0;
        sb.delete();
        pq.delete();
        repeat (2) @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_err", 32'(err), 0);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_out_last", 32'(out_last), 0);

        pq = '{pr(1, 2), pr(63, 0), pr(0, 0), pr(0, 0), pr(0, 0), pr(0, 0), pr(0, 0), pr(0, 0)};
        do_block(4'b1111);

        pq = '{pr(2, 1), pr(63, 0), pr(0, 0), pr(0, 0), pr(0, 0), pr(0, 0), pr(0, 0), pr(0, 0)};
        do_block(4'b0111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rle_block_expander.md
Name: rle_block_expander

Overview:
- Parametrised run/level expander for the JPEG decode path.
- Accepts packed words of PAIRS (run, level) entries and expands them into one BLK-coefficient block in an internal buffer.
- Streams the finished block out one coefficient per cycle with valid/ready.
- Sits between entropy-decode output storage and dequantisation/IDCT; generalises the fixed 8-pair / 64-coefficient combinational decode into a handshaked, buffered sequential block.

Parameters:
- RUN_W, 6, run field width; run of all ones (2^RUN_W-1) is the EOB code.
- LVL_W, 8, level field width, signed two's complement.
- PAIRS, 8, (run, level) pairs per input word.
- BLK, 64, coefficients per block; must be ≤ 2^RUN_W.
- IDX_W, 6, clog2(BLK), position counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- in_data  in  PAIRS*(RUN_W+LVL_W)  packed pairs; pair 0 in MSBs, each pair = {run, level}
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid && in_ready
- out_data  out  LVL_W  coefficient
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_last  out  1  high with final coefficient (BLK-th) of block
- err  out  1  one-cycle pulse on position overflow

Behaviour:
- Reset (reset low, asynchronous): state=S_LOAD, pos=0, pair index=0, written-bit vector=0, out_valid=0, out_last=0, err=0, in_ready=1 after release.
- States: S_LOAD, S_EXPAND, S_DRAIN.
- S_LOAD: in_ready=1. On handshake, latch word, pair index=0, go S_EXPAND next cycle.
- S_EXPAND: in_ready=0; one pair per cycle, pair 0 first.
  - run==EOB: block complete.
  - Else tgt=pos+run, computed IDX_W+1 wide.
    - tgt≥BLK: err pulses, nothing written, block complete.
    - Else buf[tgt]=level, written[tgt]=1, pos=tgt+1; if tgt==BLK-1, block complete.
  - Block complete: remaining pairs of the current word are discarded; go S_DRAIN next cycle.
  - Last pair consumed without completion: go S_LOAD; pos is kept, so a block spans multiple words.
- S_DRAIN:
  - out_valid=1; out_data = buf[rd] if written[rd], else 0.
  - rd starts 0 and advances on each out_valid && out_ready; out_data/out_last held stable while out_ready=0.
  - out_last=1 when rd==BLK-1.
  - On the last handshake: clear written vector, pos=0, rd=0, next cycle S_LOAD.
- Unwritten positions read as zero; no clearing cycles are needed between blocks.
- Block throughput: words×(1+pairs consumed) + BLK cycles under no backpressure.
- Simultaneous events: in_valid is ignored outside S_LOAD. An err cycle is also the block-complete cycle; the partially filled block still drains.
- Reset mid-EXPAND or mid-DRAIN: the block is abandoned, with no partial output after reset release.

Optional Feature:
- ZIGZAG_EN, requires BLK=64.
- Defined: drain reads buf[ZZ[rd]], where ZZ is the standard JPEG 8×8 zigzag-to-raster inverse table, so output is raster (row-major) order. Positions are still written in scan order.
- Undefined: output in scan order, buf[rd].
- Handshake and timing are identical in both builds.

Test Plan:
- Single word {(0,5),(2,-3),(63,x),...} -> out_data 5,0,0,-3, then 60 zeros; out_last on 64th beat; err=0; in_ready back to 1 after.
- Eight words of eight (0,k) pairs, k=1..64 -> 64 outputs equal to 1..64 in order; no EOB needed; completion on pos 63.
- Word {(40,7),(30,9),...} -> 7 at index 40; second pair tgt=71 → err pulse, 9 not written; block drains 64 beats with single nonzero at index 40.
- Backpressure: out_ready toggled 1,0,0,1 during drain -> out_data/out_last stable while low; exactly 64 accepted beats; next in_ready only after last.
- Reset asserted mid-drain at beat 20, then new block {(1,2),(63,x)} -> outputs 0,2, then 62 zeros; no stale data from the aborted block.
- ZIGZAG_EN: pairs placing 1 at scan index 2 -> raster output index 8 = 1, all others 0.
